hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It is the producer-side counterpart of operand forwarding: it covers the hazards that forwarding cannot resolve by stalling or flushing pipeline registers. It handles three cases:
- load-use stalls;
- control-transfer flushes;
- multi-cycle multiply/divide (MDU) stalls, tracked by a small FSM.

It sits beside the forwarding logic and drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_perf_cnt.sv | 23 ++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

    // A source operand conflicts with rd only if the instruction actually reads it.
    function automatic logic reg_hit(
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rd,
        input logic                 uses
    );
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter with increment enable; wraps modulo 2^CNT_W.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for load-use, redirect and multi-cycle MDU hazards.
// Optional performance counters are built when HAZARD_CTRL_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] IF_ID_Rs1,
    input  logic [REG_IDX_W-1:0] IF_ID_Rs2,
    input  logic                 IF_ID_UsesRs1,
    input  logic                 IF_ID_UsesRs2,
    input  logic [REG_IDX_W-1:0] ID_EX_Rd,
    input  logic                 ID_EX_MemRead,
    input  logic                 ID_EX_MduOp,
    input  logic                 mdu_done,
    input  logic                 EX_BranchTaken,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_bubble
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    hz_state_e state;
    hz_state_e state_nxt;
    logic      lu;
    logic      redirect;

    assign lu = ID_EX_MemRead && (ID_EX_Rd != REG_X0) &&
                (reg_hit(IF_ID_Rs1, ID_EX_Rd, IF_ID_UsesRs1) ||
                 reg_hit(IF_ID_Rs2, ID_EX_Rd, IF_ID_UsesRs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        redirect      = 1'b0;

        if (rst) begin
            // Hold the front end and fill every stage with bubbles while in reset.
            state_nxt     = RUN;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        // Redirect wins over everything, including launching an MDU op.
                        redirect    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ID_EX_MduOp && !mdu_done) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = MDU_WAIT;
                    end else if (lu && !ID_EX_MduOp) begin
                        // The load leaves EX next edge, so one bubble suffices.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic stall_inc;

    assign stall_inc = !pc_en && !rst;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect),
        .count (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_hazard_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MOD  = 1 << TB_CNT_W;

    // Output vector order: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble}
    localparam logic [5:0] O_NORMAL = 6'b111000;
    localparam logic [5:0] O_LU     = 6'b001010;
    localparam logic [5:0] O_BRANCH = 6'b111110;
    localparam logic [5:0] O_MDU    = 6'b000001;
    localparam logic [5:0] O_RESET  = 6'b000111;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
    logic       IF_ID_UsesRs1, IF_ID_UsesRs2;
    logic       ID_EX_MemRead, ID_EX_MduOp, mdu_done, EX_BranchTaken;
    logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble;
    logic [5:0] outs;
`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cycles, flush_events;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: is an MDU op outstanding, and the expected counter values.
    bit m_busy;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble};

    hazard_ctrl #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_Rs1      (IF_ID_Rs1),
        .IF_ID_Rs2      (IF_ID_Rs2),
        .IF_ID_UsesRs1  (IF_ID_UsesRs1),
        .IF_ID_UsesRs2  (IF_ID_UsesRs2),
        .ID_EX_Rd       (ID_EX_Rd),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_MduOp    (ID_EX_MduOp),
        .mdu_done       (mdu_done),
        .EX_BranchTaken (EX_BranchTaken),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble)
`ifdef HAZARD_CTRL_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
`endif
    );

    function automatic logic [5:0] model_out();
        bit rs1_dep, rs2_dep, load_use;
        rs1_dep  = IF_ID_UsesRs1 && (int'(IF_ID_Rs1) == int'(ID_EX_Rd));
        rs2_dep  = IF_ID_UsesRs2 && (int'(IF_ID_Rs2) == int'(ID_EX_Rd));
        load_use = ID_EX_MemRead && (int'(ID_EX_Rd) != 0) && (rs1_dep || rs2_dep);
        if (rst)            return O_RESET;
        if (m_busy)         return mdu_done ? O_NORMAL : O_MDU;
        if (EX_BranchTaken) return O_BRANCH;
        if (ID_EX_MduOp)    return mdu_done ? O_NORMAL : O_MDU;
        if (load_use)       return O_LU;
        return O_NORMAL;
    endfunction

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit memrd, input bit mdu, input bit done,
                          input bit br);
        IF_ID_Rs1      = 5'(rs1);
        IF_ID_Rs2      = 5'(rs2);
        IF_ID_UsesRs1  = u1;
        IF_ID_UsesRs2  = u2;
        ID_EX_Rd       = 5'(rd);
        ID_EX_MemRead  = memrd;
        ID_EX_MduOp    = mdu;
        mdu_done       = done;
        EX_BranchTaken = br;
    endtask

    task automatic set_rst(input bit r);
        rst = r;
        if (r) begin
            m_busy  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic tick();
        logic [5:0] e;
        e = model_out();
        if (!rst) begin
            if (!e[5]) m_stall = (m_stall + 1) % CNT_MOD;
            if (!m_busy && EX_BranchTaken) m_flush = (m_flush + 1) % CNT_MOD;
            if (m_busy) m_busy = !mdu_done;
            else        m_busy = !EX_BranchTaken && ID_EX_MduOp && !mdu_done;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rst(1'b1);
        tick();
        set_rst(1'b0);
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rst(1'b1);
        tick();
        #1;
        checks++;
        if (outs !== O_RESET) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs, O_RESET);
        end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++;
        if (stall_cycles !== '0 || flush_events !== '0) begin
            failures++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cycles, flush_events);
        end
`endif
        set_rst(1'b0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected %b", outs, O_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5, 1, 1, 1, 5, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL lu_rs1_stall: got %b expected %b", outs, O_LU);
        end
        tick();
        set_in(5, 1, 1, 1, 7, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL lu_release: got %b expected %b", outs, O_NORMAL);
        end
        set_in(3, 9, 1, 1, 9, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL lu_rs2_stall: got %b expected %b", outs, O_LU);
        end
        set_in(0, 1, 1, 1, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL lu_x0_no_stall: got %b expected %b", outs, O_NORMAL);
        end
        set_in(5, 1, 0, 1, 5, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL lu_unused_rs1: got %b expected %b", outs, O_NORMAL);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        set_in(5, 1, 1, 1, 5, 1, 1, 0, 1);
        #1;
        checks++;
        if (outs !== O_BRANCH) begin
            failures++;
            $display("FAIL branch_over_lu_mdu: got %b expected %b", outs, O_BRANCH);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL branch_no_mdu_wait: got %b expected %b", outs, O_NORMAL);
        end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++;
        if (flush_events !== 4'd1) begin
            failures++;
            $display("FAIL branch_flush_count: got %0d expected 1", flush_events);
        end
`endif
        tick();
    endtask

    task automatic test_mdu();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) set_in(5, 1, 1, 1, 5, 1, 1, 0, 1);
            else        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
            #1;
            checks++;
            if (outs !== O_MDU) begin
                failures++;
                $display("FAIL mdu_stall_c%0d: got %b expected %b", c, outs, O_MDU);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL mdu_release: got %b expected %b", outs, O_NORMAL);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL mdu_back_in_run: got %b expected %b", outs, O_NORMAL);
        end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 4'd4 || flush_events !== 4'd0) begin
            failures++;
            $display("FAIL mdu_counters: got stall=%0d flush=%0d expected 4/0", stall_cycles, flush_events);
        end
`endif
    endtask

    task automatic test_mdu_same_cycle();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL mdu_zero_wait: got %b expected %b", outs, O_NORMAL);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL mdu_stays_run: got %b expected %b", outs, O_NORMAL);
        end
        tick();
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_LU) begin
            failures++;
            $display("FAIL spurious_done_ignored: got %b expected %b", outs, O_LU);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        #1;
        set_rst(1'b1);
        #1;
        checks++;
        if (outs !== O_RESET) begin
            failures++;
            $display("FAIL rst_mid_wait_outputs: got %b expected %b", outs, O_RESET);
        end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++;
        if (stall_cycles !== '0) begin
            failures++;
            $display("FAIL rst_mid_wait_counter: got %0d expected 0", stall_cycles);
        end
`endif
        tick();
        set_rst(1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL rst_mid_wait_run: got %b expected %b", outs, O_NORMAL);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            failures++;
            $display("FAIL rst_pending_done: got %b expected %b", outs, O_NORMAL);
        end
    endtask

    task automatic test_counter_wrap();
`ifdef HAZARD_CTRL_PERF_CNT_EN
        do_reset();
        for (int k = 0; k < 17; k++) begin
            set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
            tick();
            set_in(5, 0, 1, 0, 6, 0, 0, 0, 0);
            tick();
        end
        #1;
        checks++;
        if (stall_cycles !== 4'd1) begin
            failures++;
            $display("FAIL stall_wrap: got %0d expected 1", stall_cycles);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] e;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0);
            set_rst($urandom_range(0, 49) == 0);
            #1;
            e = model_out();
            checks++;
            if (outs !== e) begin
                failures++;
                $display("FAIL random_outs_%0d: got %b expected %b", n, outs, e);
            end
`ifdef HAZARD_CTRL_PERF_CNT_EN
            checks++;
            if (int'(stall_cycles) != m_stall || int'(flush_events) != m_flush) begin
                failures++;
                $display("FAIL random_cnt_%0d: got stall=%0d flush=%0d expected %0d/%0d",
                         n, stall_cycles, flush_events, m_stall, m_flush);
            end
`endif
            tick();
        end
        set_rst(1'b0);
    endtask

    initial begin
        m_busy  = 1'b0;
        m_stall = 0;
        m_flush = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_mdu_same_cycle();
        test_reset_mid_wait();
        test_counter_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
